// File: rtl/seq_mult_bcd.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_bcd
// Brief    : Sequential N x N shift-add multiplier (signed/unsigned) with a
//            double-dabble binary-to-BCD converter on the product magnitude.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_bcd #(
    parameter int N      = 8,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  ena_a,
    input  logic                  ena_b,
    input  logic [N-1:0]          data,
    input  logic                  start,
    input  logic                  signed_mode,
    output logic [N-1:0]          a_q,
    output logic [N-1:0]          b_q,
    output logic                  busy,
    output logic                  done,
    output logic [2*N-1:0]        product,
    output logic                  neg,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int                 c_cnt_w     = $clog2(2*N);
    localparam logic [c_cnt_w-1:0] c_mult_last = c_cnt_w'(N-1);
    localparam logic [c_cnt_w-1:0] c_conv_last = c_cnt_w'(2*N-1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [N-1:0]       c_one_n     = N'(1);
    localparam logic [2*N-1:0]     c_one_2n    = (2*N)'(1);
    localparam logic [63:0]        c_bcd_max   = 64'(10**DIGITS) - 64'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_CONV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [N-1:0]           r_a;
    logic [N-1:0]           r_b;
    logic [2*N-1:0]         r_mcand;
    logic [N-1:0]           r_mplier;
    logic [2*N-1:0]         r_acc;
    logic                   r_sign;
    logic [2*N-1:0]         r_bin;
    logic [4*DIGITS-1:0]    r_dd;
    logic [2*N-1:0]         r_product;
    logic                   r_neg;
    logic                   r_ovf;
    logic [4*DIGITS-1:0]    r_bcd;

    logic [N-1:0]           w_mag_a;
    logic [N-1:0]           w_mag_b;
    logic [2*N-1:0]         w_acc_next;
    logic [4*DIGITS-1:0]    w_dd_adj;
    logic [4*DIGITS-1:0]    w_dd_shift;
    logic [2*N-1:0]         w_product;
    logic                   w_ovf;

    assign a_q     = r_a;
    assign b_q     = r_b;
    assign busy    = (r_state == S_MULT) || (r_state == S_CONV);
    assign done    = (r_state == S_DONE);
    assign product = r_product;
    assign neg     = r_neg;
    assign ovf     = r_ovf;
    assign bcd     = r_bcd;

    // -2**(N-1) negates to itself, which read unsigned is the correct magnitude
    assign w_mag_a = (signed_mode && r_a[N-1]) ? (~r_a + c_one_n) : r_a;
    assign w_mag_b = (signed_mode && r_b[N-1]) ? (~r_b + c_one_n) : r_b;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign w_dd_adj[4*i +: 4] = (r_dd[4*i +: 4] >= 4'd5) ?
                                        (r_dd[4*i +: 4] + 4'd3) : r_dd[4*i +: 4];
        end
    endgenerate

    assign w_dd_shift = {w_dd_adj[4*DIGITS-2:0], r_bin[2*N-1]};
    assign w_product  = r_sign ? (~r_acc + c_one_2n) : r_acc;
    assign w_ovf      = 64'(r_acc) > c_bcd_max;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_MULT;
            S_MULT: if (r_cnt == c_mult_last) w_state_next = S_CONV;
            S_CONV: if (r_cnt == c_conv_last) w_state_next = S_DONE;
            S_DONE: w_state_next = start ? S_MULT : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_sign    <= 1'b0;
            r_bin     <= '0;
            r_dd      <= '0;
            r_product <= '0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
            r_bcd     <= '0;
        end else begin
            if (!busy) begin
                if (ena_a) r_a <= data;
                if (ena_b) r_b <= data;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_mcand  <= {{N{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_sign   <= signed_mode && (r_a[N-1] ^ r_b[N-1]);
                    end
                end
                S_MULT: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= {r_mcand[2*N-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[N-1:1]};
                    if (r_cnt == c_mult_last) begin
                        r_cnt <= '0;
                        r_bin <= w_acc_next;
                        r_dd  <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_CONV: begin
                    r_bin <= {r_bin[2*N-2:0], 1'b0};
                    r_dd  <= w_dd_shift;
                    if (r_cnt == c_conv_last) begin
                        // Final shift lands directly in the result registers
                        r_cnt     <= '0;
                        r_product <= w_product;
                        r_neg     <= r_sign && (r_acc != '0);
                        r_ovf     <= w_ovf;
                        r_bcd     <= w_ovf ? '1 : w_dd_shift;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_bcd
// Brief    : Directed self-checking bench for seq_mult_bcd (DIGITS=5 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_bcd;

    logic        clk = 1'b0;
    logic        aclr;
    logic        ena_a, ena_b, start, signed_mode;
    logic [7:0]  data;

    logic [7:0]  a_q, b_q;
    logic        busy, done, neg, ovf;
    logic [15:0] product;
    logic [19:0] bcd;

    logic [7:0]  a3, b3;
    logic        busy3, done3, neg3, ovf3;
    logic [15:0] p3;
    logic [11:0] bcd3;

    int vectors = 0;
    int miscompares = 0;
    int nbusy;
    int ndone;

    always #5 clk = ~clk;

    seq_mult_bcd #(.N(8), .DIGITS(5)) dut (
        .clk(clk), .aclr(aclr), .ena_a(ena_a), .ena_b(ena_b), .data(data),
        .start(start), .signed_mode(signed_mode), .a_q(a_q), .b_q(b_q),
        .busy(busy), .done(done), .product(product), .neg(neg), .ovf(ovf), .bcd(bcd)
    );

    seq_mult_bcd #(.N(8), .DIGITS(3)) dut3 (
        .clk(clk), .aclr(aclr), .ena_a(ena_a), .ena_b(ena_b), .data(data),
        .start(start), .signed_mode(signed_mode), .a_q(a3), .b_q(b3),
        .busy(busy3), .done(done3), .product(p3), .neg(neg3), .ovf(ovf3), .bcd(bcd3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic [7:0] a, input logic [7:0] b);
        data = a; ena_a = 1'b1; tick(); ena_a = 1'b0;
        data = b; ena_b = 1'b1; tick(); ena_b = 1'b0;
    endtask

    // Counts busy cycles until done, bounded; leaves time inside the done cycle
    task automatic wait_done(input string tag);
        int n = 0;
        nbusy = 0;
        while (!done && n < 200) begin
            if (busy) nbusy++;
            n++;
            tick();
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic run(input string tag, input logic sm);
        signed_mode = sm; start = 1'b1; tick(); start = 1'b0;
        wait_done(tag);
    endtask

    task automatic count_dones(input int cycles);
        ndone = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done) ndone++;
            tick();
        end
    endtask

    initial begin
        aclr = 1'b0; ena_a = 1'b0; ena_b = 1'b0; start = 1'b0;
        signed_mode = 1'b0; data = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", 64'(product), 64'd0);
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_a", 64'(a_q), 64'd0);
        aclr = 1'b1;
        tick();

        // 13 x 11 unsigned, 24 busy cycles, single-cycle done
        ld(8'd13, 8'd11);
        chk("ld_a", 64'(a_q), 64'd13);
        chk("ld_b", 64'(b_q), 64'd11);
        run("t1", 1'b0);
        chk("t1_busy_cycles", 64'(nbusy), 64'd24);
        chk("t1_busy_in_done", 64'(busy), 64'd0);
        chk("t1_prod", 64'(product), 64'h008F);
        chk("t1_bcd", 64'(bcd), 64'h00143);
        chk("t1_neg", 64'(neg), 64'd0);
        chk("t1_ovf", 64'(ovf), 64'd0);
        tick();
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_hold", 64'(product), 64'h008F);

        // Max unsigned, then zero
        ld(8'd255, 8'd255);
        run("t2", 1'b0);
        chk("t2_prod", 64'(product), 64'hFE01);
        chk("t2_bcd", 64'(bcd), 64'h65025);
        tick();
        ld(8'd0, 8'd255);
        run("t2z", 1'b0);
        chk("t2z_prod", 64'(product), 64'h0000);
        chk("t2z_bcd", 64'(bcd), 64'h00000);
        tick();

        // Signed cases; A=B=0x80 loaded in one shared cycle
        ld(8'hFD, 8'd7);
        run("t3a", 1'b1);
        chk("t3a_prod", 64'(product), 64'hFFEB);
        chk("t3a_neg", 64'(neg), 64'd1);
        chk("t3a_bcd", 64'(bcd), 64'h00021);
        tick();
        data = 8'h80; ena_a = 1'b1; ena_b = 1'b1; tick(); ena_a = 1'b0; ena_b = 1'b0;
        chk("t3b_a", 64'(a_q), 64'h80);
        chk("t3b_b", 64'(b_q), 64'h80);
        run("t3b", 1'b1);
        chk("t3b_prod", 64'(product), 64'h4000);
        chk("t3b_neg", 64'(neg), 64'd0);
        chk("t3b_bcd", 64'(bcd), 64'h16384);
        tick();
        ld(8'hFD, 8'd0);
        run("t3c", 1'b1);
        chk("t3c_prod", 64'(product), 64'h0000);
        chk("t3c_neg", 64'(neg), 64'd0);
        tick();

        // Overflow boundary on the 3-digit instance
        ld(8'd40, 8'd30);
        run("t4a", 1'b0);
        chk("t4a_p3", 64'(p3), 64'd1200);
        chk("t4a_ovf3", 64'(ovf3), 64'd1);
        chk("t4a_bcd3", 64'(bcd3), 64'hFFF);
        chk("t4a_ovf5", 64'(ovf), 64'd0);
        chk("t4a_bcd5", 64'(bcd), 64'h01200);
        tick();
        ld(8'd9, 8'd111);
        run("t4b", 1'b0);
        chk("t4b_p3", 64'(p3), 64'd999);
        chk("t4b_ovf3", 64'(ovf3), 64'd0);
        chk("t4b_bcd3", 64'(bcd3), 64'h999);
        tick();

        // start and ena_a while busy are ignored
        ld(8'd13, 8'd11);
        signed_mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        start = 1'b1; ena_a = 1'b1; data = 8'd99; tick();
        start = 1'b0; ena_a = 1'b0;
        wait_done("t5a");
        chk("t5a_a", 64'(a_q), 64'd13);
        chk("t5a_prod", 64'(product), 64'h008F);
        tick();
        count_dones(40);
        chk("t5a_extra_done", 64'(ndone), 64'd0);

        // start held through DONE chains directly into the next op
        start = 1'b1; tick();
        wait_done("t5b1");
        tick();
        chk("t5b_b2b_busy", 64'(busy), 64'd1);
        chk("t5b_b2b_done", 64'(done), 64'd0);
        start = 1'b0;
        wait_done("t5b2");
        chk("t5b2_busy_cycles", 64'(nbusy), 64'd24);
        chk("t5b2_prod", 64'(product), 64'h008F);
        tick();

        // Asynchronous reset mid-operation
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        #1 aclr = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_a", 64'(a_q), 64'd0);
        chk("t6_prod", 64'(product), 64'd0);
        chk("t6_bcd", 64'(bcd), 64'd0);
        #1 aclr = 1'b1;
        tick();
        count_dones(40);
        chk("t6_no_done", 64'(ndone), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
